// File: rtl/ir_ac_frame_builder.sv
// Debounces the five AC front-panel keys, holds the settings and publishes one frame pair per change.
// Key edge to frame_update takes 3 cycles when idle; further changes while busy merge into one later frame.
module ir_ac_frame_builder #(
    parameter int unsigned DEB_CYC    = 2_500_000,
    parameter int unsigned TX_TIMEOUT = 30_000_000,
    parameter logic [4:0]  T_RESET    = 5'd26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_pwr,
    input  logic        key_mode,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_fan,
    input  logic        tx_done,
    output logic [31:0] IR_in_data35_1,
    output logic [2:0]  IR_in_data35_0,
    output logic [31:0] IR_in_data32,
    output logic        frame_update,
    output logic        busy
);

    localparam int unsigned    DCW      = $clog2(DEB_CYC + 1);
    localparam int unsigned    TCW      = $clog2(TX_TIMEOUT + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYC - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TX_TIMEOUT - 1);
    localparam logic [3:0]     TC_RESET = 4'(T_RESET - 5'd16);
    localparam logic [3:0]     TC_MAX   = 4'd14;

    typedef enum logic [1:0] {ST_IDLE, ST_BUILD, ST_PUBLISH, ST_WAIT_TX} state_t;

    // Key bit order: 4 pwr, 3 mode, 2 up, 1 down, 0 fan
    logic [4:0]     key_raw;
    logic [4:0]     sync1_q, sync2_q, deb_q;
    logic [DCW-1:0] deb_cnt_q [5];
    logic [4:0]     key_edge;

    logic       power_q, power_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] tcode_q, tcode_d;
    logic [1:0] fan_q, fan_d;
    logic       set_chg;

    state_t         state_q, state_d;
    logic           pending_q, pending_d;
    logic           busy_q, busy_d;
    logic           fu_q;
    logic [1:0]     seq_q, seq_nx;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           txd_q;
    logic           tx_rise, tx_end, load_out;
    logic [34:0]    f35_d, f35_q;
    logic [31:0]    g32_d, g32_q;
    logic [3:0]     csum;

    assign key_raw = {key_pwr, key_mode, key_up, key_down, key_fan};

    always_comb begin
        key_edge = '0;
        for (int k = 0; k < 5; k++) begin
            key_edge[k] = sync2_q[k] & ~deb_q[k] & (deb_cnt_q[k] == DEB_LAST);
        end
    end

    // The counter only runs while the synchronised level disagrees with the accepted one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int k = 0; k < 5; k++) deb_cnt_q[k] <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            for (int k = 0; k < 5; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    deb_cnt_q[k] <= '0;
                end else if (deb_cnt_q[k] == DEB_LAST) begin
                    deb_q[k]     <= sync2_q[k];
                    deb_cnt_q[k] <= '0;
                end else begin
                    deb_cnt_q[k] <= deb_cnt_q[k] + DCW'(1);
                end
            end
        end
    end

    always_comb begin
        power_d = power_q;
        mode_d  = mode_q;
        tcode_d = tcode_q;
        fan_d   = fan_q;
        if (key_edge[4]) power_d = ~power_q;
        if (power_q) begin
            if (key_edge[3]) mode_d = (mode_q == 3'd4) ? 3'd0 : mode_q + 3'd1;
            if (key_edge[0]) fan_d = fan_q + 2'd1;
            // Simultaneous up and down cancel each other
            if (key_edge[2] && !key_edge[1] && tcode_q != TC_MAX) tcode_d = tcode_q + 4'd1;
            if (key_edge[1] && !key_edge[2] && tcode_q != 4'd0)   tcode_d = tcode_q - 4'd1;
        end
        set_chg = {power_d, mode_d, tcode_d, fan_d} != {power_q, mode_q, tcode_q, fan_q};
    end

    always_comb begin
        tx_rise  = tx_done & ~txd_q;
        load_out = (state_q == ST_BUILD);
        tx_end   = (state_q == ST_WAIT_TX) && (tx_rise || tmo_q == TMO_LAST);
        seq_nx   = seq_q + 2'd1;
        csum     = {1'b0, mode_q} + tcode_q + {2'b0, fan_q} + {3'b0, power_q} + 4'hA;
        f35_d    = {mode_q, power_q, fan_q, 4'd0, tcode_q, 14'd0, 7'b1010010};
        g32_d    = {csum, 26'd0, seq_nx};

        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pending_q) state_d = ST_BUILD;
            ST_BUILD:   state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_end) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // A change landing on the load edge is not in the frame being loaded, so it stays pending
        pending_d = set_chg ? 1'b1 : (load_out ? 1'b0 : pending_q);
        busy_d    = load_out ? 1'b1 : (tx_end ? 1'b0 : busy_q);
        tmo_d     = (state_q == ST_PUBLISH || state_q == ST_WAIT_TX) ? tmo_q + TCW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_q   <= 1'b0;
            mode_q    <= 3'd0;
            tcode_q   <= TC_RESET;
            fan_q     <= 2'd0;
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            fu_q      <= 1'b0;
            seq_q     <= 2'd0;
            tmo_q     <= '0;
            txd_q     <= 1'b0;
            f35_q     <= '0;
            g32_q     <= '0;
        end else begin
            power_q   <= power_d;
            mode_q    <= mode_d;
            tcode_q   <= tcode_d;
            fan_q     <= fan_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            fu_q      <= load_out;
            tmo_q     <= tmo_d;
            txd_q     <= tx_done;
            if (load_out) begin
                seq_q <= seq_nx;
                f35_q <= f35_d;
                g32_q <= g32_d;
            end
        end
    end

    assign IR_in_data35_1 = f35_q[34:3];
    assign IR_in_data35_0 = f35_q[2:0];
    assign IR_in_data32   = g32_q;
    assign frame_update   = fu_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ir_ac_frame_builder.sv
// Directed plus randomized key sequences against a settings/frame reference model.
module tb_ir_ac_frame_builder;

    localparam int DEB = 16;
    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  keys = '0;
    logic        tx_done = 1'b0;
    logic [31:0] IR_in_data35_1;
    logic [2:0]  IR_in_data35_0;
    logic [31:0] IR_in_data32;
    logic        frame_update;
    logic        busy;

    ir_ac_frame_builder #(.DEB_CYC(DEB), .TX_TIMEOUT(TMO), .T_RESET(5'd26)) dut (
        .clk(clk), .rst(rst),
        .key_pwr(keys[4]), .key_mode(keys[3]), .key_up(keys[2]), .key_down(keys[1]), .key_fan(keys[0]),
        .tx_done(tx_done),
        .IR_in_data35_1(IR_in_data35_1), .IR_in_data35_0(IR_in_data35_0), .IR_in_data32(IR_in_data32),
        .frame_update(frame_update), .busy(busy)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          fu_cnt = 0;
    int          fu_cyc = 0;
    logic [34:0] cap_f;
    logic [31:0] cap_g;
    always @(negedge clk) begin
        if (frame_update === 1'b1) begin
            fu_cnt++;
            fu_cyc = cyc;
            cap_f  = {IR_in_data35_1, IR_in_data35_0};
            cap_g  = IR_in_data32;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: settings as plain integers
    int m_power, m_mode, m_tcode, m_fan, m_seq;
    bit m_pending;
    int press_cyc;
    bit last_chg;

    function automatic void m_reset();
        m_power = 0; m_mode = 0; m_tcode = 10; m_fan = 0; m_seq = 0; m_pending = 0;
    endfunction

    function automatic bit m_apply(input logic [4:0] m);
        int op, om, ot, of;
        op = m_power; om = m_mode; ot = m_tcode; of = m_fan;
        if (m[4]) m_power = 1 - m_power;
        if (op == 1) begin
            if (m[3]) m_mode = (m_mode + 1) % 5;
            if (m[0]) m_fan = (m_fan + 1) % 4;
            if (m[2] && !m[1] && m_tcode < 14) m_tcode = m_tcode + 1;
            if (m[1] && !m[2] && m_tcode > 0)  m_tcode = m_tcode - 1;
        end
        return (op != m_power) || (om != m_mode) || (ot != m_tcode) || (of != m_fan);
    endfunction

    function automatic logic [63:0] exp_f();
        return (64'(m_mode) << 32) | (64'(m_power) << 31) | (64'(m_fan) << 29) |
               (64'(m_tcode) << 21) | 64'd82;
    endfunction

    function automatic logic [63:0] exp_g();
        return (64'((m_mode + m_tcode + m_fan + m_power + 10) % 16) << 28) | 64'(m_seq);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_F"}, 64'(cap_f), exp_f());
        chk({tag, "_G"}, 64'(cap_g), exp_g());
    endtask

    task automatic do_press(input logic [4:0] m, input int hold, input bit chatter,
                            input bit idle, input string tag);
        int n0;
        bit chg;
        n0 = fu_cnt;
        if (chatter) begin
            for (int i = 0; i < 3; i++) begin
                keys = m;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                keys = '0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        keys = m;
        press_cyc = cyc;
        repeat (hold) @(negedge clk);
        keys = '0;
        repeat (DEB + 6) @(negedge clk);
        chg = 1'b0;
        if (hold >= DEB + 3) chg = m_apply(m);
        last_chg = chg;
        if (idle) begin
            if (chg) m_seq = (m_seq + 1) % 4;
            chk({tag, "_count"}, 64'(fu_cnt - n0), 64'(chg));
            if (chg) begin
                chk_frame(tag);
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end else begin
            chk({tag, "_count_busy"}, 64'(fu_cnt - n0), 64'd0);
            if (chg) m_pending = 1'b1;
        end
    endtask

    task automatic tx_complete(input string tag);
        int n0;
        n0 = fu_cnt;
        tx_done = 1'b1;
        repeat (2) @(negedge clk);
        tx_done = 1'b0;
        repeat (6) @(negedge clk);
        if (m_pending) begin
            m_pending = 1'b0;
            m_seq = (m_seq + 1) % 4;
            chk({tag, "_count"}, 64'(fu_cnt - n0), 64'd1);
            chk_frame(tag);
            chk({tag, "_busy"}, 64'(busy), 64'd1);
        end else begin
            chk({tag, "_count"}, 64'(fu_cnt - n0), 64'd0);
            chk({tag, "_busy"}, 64'(busy), 64'd0);
        end
    endtask

    logic [4:0]  masks [6];
    logic [34:0] f_ref;

    initial begin
        int n0, k, p_cyc, r, hold;
        masks[0] = 5'b10000; masks[1] = 5'b01000; masks[2] = 5'b00100;
        masks[3] = 5'b00010; masks[4] = 5'b00001; masks[5] = 5'b00110;
        m_reset();
        f_ref = {3'd0, 1'b1, 2'd0, 4'd0, 4'd10, 14'd0, 7'b1010010};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_d35", {29'd0, IR_in_data35_1, IR_in_data35_0}, 64'd0);
        chk("reset_d32", 64'(IR_in_data32), 64'd0);
        chk("reset_ctl", {62'd0, frame_update, busy}, 64'd0);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_frame_after_reset", 64'(fu_cnt), 64'd0);

        // Power on: first frame, latency and fixed frame contents
        do_press(5'b10000, DEB + 10, 1'b0, 1'b1, "pwr_on");
        chk("pwr_F_const", 64'(cap_f), 64'(f_ref));
        chk("pwr_seq", 64'(cap_g[1:0]), 64'd1);
        chk("pwr_latency", 64'((fu_cyc - press_cyc >= DEB + 3) && (fu_cyc - press_cyc <= DEB + 5)), 64'd1);
        tx_complete("pwr_done");

        // Short glitch is rejected, a full press is accepted
        do_press(5'b00100, DEB / 2, 1'b0, 1'b1, "glitch_up");
        do_press(5'b00100, DEB + 10, 1'b1, 1'b1, "up_11");
        tx_complete("up_11_done");

        // Climb to 30 degC, then saturate
        for (int i = 0; i < 3; i++) begin
            do_press(5'b00100, DEB + 10, 1'b0, 1'b1, $sformatf("up_climb%0d", i));
            tx_complete("climb_done");
        end
        do_press(5'b00100, DEB + 10, 1'b0, 1'b1, "up_sat0");
        do_press(5'b00100, DEB + 10, 1'b0, 1'b1, "up_sat1");

        // Mode wraps through all five values, seq wraps too
        for (int i = 0; i < 5; i++) begin
            do_press(5'b01000, DEB + 10, 1'b0, 1'b1, $sformatf("mode%0d", i));
            tx_complete("mode_done");
        end

        // Up and down together cancel
        do_press(5'b00110, DEB + 10, 1'b0, 1'b1, "up_down");

        // Changes while busy merge into one frame after tx_done
        do_press(5'b00001, DEB + 10, 1'b0, 1'b1, "coal_fan");
        do_press(5'b01000, DEB + 10, 1'b0, 1'b0, "coal_mode");
        do_press(5'b00001, DEB + 10, 1'b0, 1'b0, "coal_fan2");
        do_press(5'b00010, DEB + 10, 1'b0, 1'b0, "coal_down");
        tx_complete("coal");
        tx_complete("coal_end");

        // Timeout releases busy; the pending change then publishes
        do_press(5'b00001, DEB + 10, 1'b0, 1'b1, "tmo_a");
        p_cyc = fu_cyc;
        do_press(5'b01000, DEB + 10, 1'b0, 1'b0, "tmo_b");
        chk("tmo_busy_mid", 64'(busy), 64'd1);
        n0 = fu_cnt;
        k = 0;
        while (fu_cnt == n0 && k < TMO + 100) begin
            @(negedge clk);
            k++;
        end
        m_pending = 1'b0;
        m_seq = (m_seq + 1) % 4;
        chk("tmo_pending_count", 64'(fu_cnt - n0), 64'd1);
        chk("tmo_delay", 64'((fu_cyc - p_cyc >= TMO + 1) && (fu_cyc - p_cyc <= TMO + 3)), 64'd1);
        chk_frame("tmo_pending");
        p_cyc = fu_cyc;
        while (cyc < p_cyc + TMO - 5) @(negedge clk);
        chk("tmo_busy_before", 64'(busy), 64'd1);
        while (cyc < p_cyc + TMO + 3) @(negedge clk);
        chk("tmo_busy_after", 64'(busy), 64'd0);

        // Randomized single presses from idle
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 5);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(2, DEB - 4) : $urandom_range(DEB + 4, DEB + 12);
            do_press(masks[r], hold, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", i));
            if (last_chg) tx_complete($sformatf("rnd%0d_done", i));
        end

        // Reset in the middle of WAIT_TX
        do_press(5'b10000, DEB + 10, 1'b0, 1'b1, "rst_pre");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_d35", {29'd0, IR_in_data35_1, IR_in_data35_0}, 64'd0);
        chk("rst_mid_d32", 64'(IR_in_data32), 64'd0);
        chk("rst_mid_ctl", {62'd0, frame_update, busy}, 64'd0);
        rst = 1'b1;
        m_reset();
        n0 = fu_cnt;
        repeat (40) @(negedge clk);
        chk("rst_mid_quiet", 64'(fu_cnt - n0), 64'd0);
        do_press(5'b10000, DEB + 10, 1'b0, 1'b1, "rst_post");
        chk("rst_post_F_const", 64'(cap_f), 64'(f_ref));
        tx_complete("rst_post_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
